// File: rtl/game_pkg.sv
// game_pkg: shared state encoding and timer sizing for the game-flow controller.
package game_pkg;
  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_SHOW   = 2'd1,
    ST_GAME   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;
  function automatic int tmr_w(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m < 1 ? 1 : $clog2(m + 1);
  endfunction
endpackage

// File: rtl/btn_conditioner.sv
// btn_conditioner: two-flop synchroniser, DB_LEN-sample debounce and one-pulse on the debounced press.
module btn_conditioner #(
  parameter int DB_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);
  logic [1:0]        r_sync;
  logic [DB_LEN-1:0] r_sh;
  logic              r_db;
  logic              r_pulse;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_sh    <= '0;
      r_db    <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_sh    <= DB_LEN'({r_sh, r_sync[1]});
      r_db    <= (&r_sh) | (r_db & (|r_sh));
      r_pulse <= (&r_sh) & ~r_db;
    end
  end
  assign o_pulse = r_pulse;
endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: INIT/SHOW/GAME/FINISH sequencer with key matching, time limit, miss limit and hints.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int LEN       = 4,
  parameter int CODE_W    = 4,
  parameter int DB_LEN    = 4,
  parameter int SHOW_CYC  = 100_000_000,
  parameter int TIME_CYC  = 1_000_000_000,
  parameter int HINT_CYC  = 50_000_000,
  parameter int MAX_HINTS = 3,
  parameter int MAX_MISS  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_btn,
  input  logic                  hint_btn,
  input  logic                  key_valid,
  input  logic [CODE_W-1:0]     key_code,
  input  logic [LEN*CODE_W-1:0] target,
  output logic [1:0]            state,
  output logic [4:0]            pos,
  output logic                  show_en,
  output logic                  hint_on,
  output logic [3:0]            hints_left,
  output logic [3:0]            miss_cnt,
  output logic                  pass,
  output logic                  fail
);
  localparam int TW = tmr_w(SHOW_CYC, TIME_CYC, HINT_CYC);
  logic                  w_start_p, w_hint_p;
  state_t                r_state, w_state;
  logic [LEN*CODE_W-1:0] r_tgt, w_tgt;
  logic [TW-1:0]         r_tmr, w_tmr, r_htmr, w_htmr;
  logic [4:0]            r_pos, w_pos;
  logic [3:0]            r_miss, w_miss, r_hints, w_hints;
  logic                  r_hint_on, w_hint_on, r_show, w_show, r_pass, w_pass, r_fail, w_fail;
  logic [CODE_W-1:0]     w_exp;
  logic                  w_hit, w_win, w_lose;
  btn_conditioner #(.DB_LEN(DB_LEN)) u_start (.clk(clk), .rst(rst), .i_btn(start_btn), .o_pulse(w_start_p));
  btn_conditioner #(.DB_LEN(DB_LEN)) u_hint  (.clk(clk), .rst(rst), .i_btn(hint_btn),  .o_pulse(w_hint_p));
  assign w_exp = r_tgt[r_pos[3:0]*CODE_W +: CODE_W];
  always_comb begin
    w_state   = r_state;
    w_tgt     = r_tgt;
    w_tmr     = r_tmr;
    w_htmr    = r_htmr;
    w_pos     = r_pos;
    w_miss    = r_miss;
    w_hints   = r_hints;
    w_hint_on = r_hint_on;
    w_show    = r_show;
    w_pass    = r_pass;
    w_fail    = r_fail;
    w_hit     = key_valid && key_code == w_exp;
    w_win     = r_state == ST_GAME && w_hit && r_pos == 5'(LEN-1);
    // a winning key beats both the miss limit and the timeout in the same cycle
    w_lose    = r_state == ST_GAME && ((key_valid && !w_hit && r_miss == 4'(MAX_MISS-1)) || r_tmr == '0);
    case (r_state)
      ST_INIT: if (w_start_p) begin
        w_state = ST_SHOW;
        w_tgt   = target;
        w_tmr   = TW'(SHOW_CYC);
        w_show  = 1'b1;
      end
      ST_SHOW: if (w_start_p || (SHOW_CYC != 0 && r_tmr == '0)) begin
        w_state = ST_GAME;
        w_pos   = '0;
        w_miss  = '0;
        w_hints = 4'(MAX_HINTS);
        w_tmr   = TW'(TIME_CYC);
        w_show  = 1'b0;
      end else begin
        w_tmr = r_tmr == '0 ? r_tmr : r_tmr - 1'b1;
      end
      ST_GAME: begin
        w_tmr = r_tmr == '0 ? r_tmr : r_tmr - 1'b1;
        if (r_hint_on) begin
          w_hint_on = r_htmr != '0;
          w_htmr    = r_htmr == '0 ? r_htmr : r_htmr - 1'b1;
        end else if (w_hint_p && r_hints != '0) begin
          w_hint_on = 1'b1;
          w_hints   = r_hints - 1'b1;
          w_htmr    = TW'(HINT_CYC);
        end
        if (key_valid) begin
          w_pos  = w_hit ? r_pos + 1'b1 : '0;
          w_miss = w_hit ? r_miss : r_miss + 1'b1;
        end
        w_show = w_hint_on;
        if (w_win || w_lose) begin
          w_state   = ST_FINISH;
          w_pass    = w_win;
          w_fail    = !w_win;
          w_hint_on = 1'b0;
          w_show    = 1'b0;
          w_htmr    = '0;
        end
      end
      default: if (w_start_p) begin
        w_state = ST_INIT;
        w_tgt   = '0;
        w_tmr   = '0;
        w_htmr  = '0;
        w_pos   = '0;
        w_miss  = '0;
        w_hints = '0;
        w_pass  = 1'b0;
        w_fail  = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_INIT;
      r_tgt     <= '0;
      r_tmr     <= '0;
      r_htmr    <= '0;
      r_pos     <= '0;
      r_miss    <= '0;
      r_hints   <= '0;
      r_hint_on <= 1'b0;
      r_show    <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_tgt     <= w_tgt;
      r_tmr     <= w_tmr;
      r_htmr    <= w_htmr;
      r_pos     <= w_pos;
      r_miss    <= w_miss;
      r_hints   <= w_hints;
      r_hint_on <= w_hint_on;
      r_show    <= w_show;
      r_pass    <= w_pass;
      r_fail    <= w_fail;
    end
  end
  assign state      = r_state;
  assign pos        = r_pos;
  assign show_en    = r_show;
  assign hint_on    = r_hint_on;
  assign hints_left = r_hints;
  assign miss_cnt   = r_miss;
  assign pass       = r_pass;
  assign fail       = r_fail;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: scoreboard bench; expected output snapshots are queued per cycle and compared after each edge.
module tb_game_flow_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_btn = 1'b0;
  logic        hint_btn = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = '0;
  logic [15:0] target = {4'h3, 4'h2, 4'h1, 4'h0};
  logic [1:0]  state;
  logic [4:0]  pos;
  logic        show_en, hint_on, pass, fail;
  logic [3:0]  hints_left, miss_cnt;
  game_flow_ctrl #(
    .LEN(4), .CODE_W(4), .DB_LEN(4), .SHOW_CYC(20), .TIME_CYC(200),
    .HINT_CYC(10), .MAX_HINTS(2), .MAX_MISS(3)
  ) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .hint_btn(hint_btn),
    .key_valid(key_valid), .key_code(key_code), .target(target),
    .state(state), .pos(pos), .show_en(show_en), .hint_on(hint_on),
    .hints_left(hints_left), .miss_cnt(miss_cnt), .pass(pass), .fail(fail)
  );
  always #5 clk = ~clk;
  typedef struct {
    string       tag;
    logic [18:0] v;
  } exp_t;
  exp_t        sb[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [1:0]  m_state;
  logic [4:0]  m_pos;
  logic        m_show, m_hon, m_pass, m_fail;
  logic [3:0]  m_hl, m_miss;
  task automatic check_eq(input string tag, input logic [18:0] got, input logic [18:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got={st,pos,show,hint,hl,miss,pass,fail}=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic model_clear();
    m_state = 2'd0; m_pos = '0; m_show = 1'b0; m_hon = 1'b0;
    m_hl = '0; m_miss = '0; m_pass = 1'b0; m_fail = 1'b0;
  endtask
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, {state, pos, show_en, hint_on, hints_left, miss_cnt, pass, fail}, e.v);
    end
  endtask
  task automatic step(input string tag);
    sb.push_back('{tag, {m_state, m_pos, m_show, m_hon, m_hl, m_miss, m_pass, m_fail}});
    tick();
  endtask
  // four clean samples then release; the controller reacts on the following (8th) edge
  task automatic press(input bit h);
    for (int i = 0; i < 7; i++) begin
      if (h) hint_btn = (i < 4);
      else start_btn = (i < 4);
      step(h ? "hint_hold" : "start_hold");
    end
  endtask
  task automatic key(input logic [3:0] code, input string tag);
    key_valid = 1'b1;
    key_code  = code;
    step(tag);
    key_valid = 1'b0;
  endtask
  task automatic to_game();
    press(1'b0);
    m_state = 2'd1; m_show = 1'b1;
    step("enter_show");
    press(1'b0);
    m_state = 2'd2; m_show = 1'b0; m_hl = 4'd2; m_pos = '0; m_miss = '0;
    step("start_to_game");
  endtask
  task automatic back_to_init(input string tag);
    press(1'b0);
    model_clear();
    step(tag);
  endtask
  initial begin
    model_clear();
    step("reset0");
    step("reset1");
    rst = 1'b0;
    step("reset_release");
    start_btn = 1'b1;
    step("glitch");
    step("glitch");
    start_btn = 1'b0;
    for (int i = 0; i < 10; i++) step("glitch_idle");
    press(1'b0);
    m_state = 2'd1; m_show = 1'b1;
    step("show_enter");
    for (int i = 0; i < 20; i++) step("show_wait");
    m_state = 2'd2; m_show = 1'b0; m_hl = 4'd2;
    step("show_auto_adv");
    for (int i = 0; i < 3; i++) begin
      m_pos = 5'(i + 1);
      key(4'(i), "win_key");
    end
    m_pos = 5'd4; m_state = 2'd3; m_pass = 1'b1;
    key(4'd3, "win_pass");
    key(4'd0, "finish_key_ign");
    press(1'b1);
    step("finish_hint_ign");
    back_to_init("finish_to_init");
    to_game();
    press(1'b0);
    step("game_start_ign");
    m_pos = 5'd1;
    key(4'd0, "miss_k0");
    m_pos = 5'd0; m_miss = 4'd1;
    key(4'd5, "miss_k5");
    m_miss = 4'd2;
    key(4'd7, "miss_k7");
    m_miss = 4'd3; m_state = 2'd3; m_fail = 1'b1;
    key(4'd9, "miss_fail");
    key(4'd0, "miss_key_ign");
    back_to_init("miss_to_init");
    to_game();
    for (int i = 0; i < 200; i++) step("timeout_wait");
    m_state = 2'd3; m_fail = 1'b1;
    step("timeout_fail");
    back_to_init("timeout_to_init");
    to_game();
    for (int i = 0; i < 3; i++) begin
      m_pos = 5'(i + 1);
      key(4'(i), "tw_key");
    end
    for (int i = 0; i < 197; i++) step("tw_wait");
    m_pos = 5'd4; m_state = 2'd3; m_pass = 1'b1;
    key(4'd3, "timeout_win_pass");
    back_to_init("tw_to_init");
    to_game();
    press(1'b1);
    m_hon = 1'b1; m_show = 1'b1; m_hl = 4'd1;
    step("hint1_on");
    press(1'b1);
    step("hint_during_ign");
    step("hint1_hold");
    step("hint1_hold");
    m_hon = 1'b0; m_show = 1'b0;
    step("hint1_off");
    press(1'b1);
    m_hon = 1'b1; m_show = 1'b1; m_hl = 4'd0;
    step("hint2_on");
    for (int i = 0; i < 10; i++) step("hint2_hold");
    m_hon = 1'b0; m_show = 1'b0;
    step("hint2_off");
    press(1'b1);
    step("hint3_ign");
    rst = 1'b1;
    model_clear();
    step("hint_rst");
    rst = 1'b0;
    to_game();
    m_pos = 5'd1;
    key(4'd0, "rst_k0");
    m_pos = 5'd2;
    key(4'd1, "rst_k1");
    press(1'b1);
    m_hon = 1'b1; m_show = 1'b1; m_hl = 4'd1;
    step("rst_pre_hint");
    rst = 1'b1;
    model_clear();
    step("rst_mid_game");
    rst = 1'b0;
    step("rst_after");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
